// File: rtl/rand_stream.sv
// Multi-channel xorshift64 random sample stream with warm-up discard, ready/valid
// handshake and raw / unit / signed fixed-point output formatting.
`timescale 1ns/1ps
module rand_stream #(
    parameter int          WIDTH        = 64,
    parameter int          CHANNELS     = 3,
    parameter int          FRAC         = 32,
    parameter int          WARMUP       = 16,
    parameter logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001,
    parameter logic [1:0]  DEFAULT_MODE = 2'd0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_seed_load,
    input  logic [63:0]               i_seed_in,
    input  logic [1:0]                i_mode_in,
    input  logic                      i_rand_ready,
    output logic                      o_rand_valid,
    output logic [CHANNELS*WIDTH-1:0] o_rand_out,
    output logic [31:0]               o_draw_count
);

    localparam logic [63:0] GOLDEN    = 64'h9E37_79B9_7F4A_7C15;
    localparam logic [7:0]  WARM_INIT = 8'(WARMUP);

    typedef enum logic {ST_WARM, ST_RUN} state_t;
    localparam state_t INIT_STATE = (WARMUP > 0) ? ST_WARM : ST_RUN;

    state_t      r_fsm;
    logic [63:0] r_s [CHANNELS];
    logic [1:0]  r_mode;
    logic [7:0]  r_warm_cnt;
    logic [31:0] r_draw_count;

    function automatic logic [63:0] f_step(input logic [63:0] s);
        logic [63:0] v;
        v = s ^ (s << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    // Golden-ratio spread keeps channels decorrelated; a zero state would lock xorshift.
    function automatic logic [63:0] f_seed(input logic [63:0] seed, input int c);
        logic [63:0] v;
        v = seed ^ (64'(c) * GOLDEN);
        return (v == 64'd0) ? 64'd1 : v;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < CHANNELS; c++) r_s[c] <= f_seed(DEFAULT_SEED, c);
            r_mode       <= DEFAULT_MODE;
            r_warm_cnt   <= WARM_INIT;
            r_draw_count <= 32'd0;
            r_fsm        <= INIT_STATE;
        end else if (i_seed_load) begin
            for (int c = 0; c < CHANNELS; c++) r_s[c] <= f_seed(i_seed_in, c);
            r_mode       <= i_mode_in;
            r_warm_cnt   <= WARM_INIT;
            r_draw_count <= 32'd0;
            r_fsm        <= INIT_STATE;
        end else begin
            case (r_fsm)
                ST_WARM: begin
                    for (int c = 0; c < CHANNELS; c++) r_s[c] <= f_step(r_s[c]);
                    r_warm_cnt <= r_warm_cnt - 8'd1;
                    if (r_warm_cnt == 8'd1) r_fsm <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_rand_ready) begin
                        for (int c = 0; c < CHANNELS; c++) r_s[c] <= f_step(r_s[c]);
                        r_draw_count <= r_draw_count + 32'd1;
                    end
                end
            endcase
        end
    end

    assign o_rand_valid = (r_fsm == ST_RUN);
    assign o_draw_count = r_draw_count;

    // Mode 1 keeps the fraction only; mode 2 sign-extends from bit FRAC.
    always_comb begin
        o_rand_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < WIDTH; b++) begin
                case (r_mode)
                    2'd1:    o_rand_out[c*WIDTH+b] = (b < FRAC) ? r_s[c][b] : 1'b0;
                    2'd2:    o_rand_out[c*WIDTH+b] = (b <= FRAC) ? r_s[c][b] : r_s[c][FRAC];
                    default: o_rand_out[c*WIDTH+b] = r_s[c][b];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rand_stream.sv
// Bench for rand_stream: behavioural model with per-cycle compare on a 3-channel
// instance, plus literal checks on a 1-channel, no-warm-up instance.
`timescale 1ns/1ps
module tb_rand_stream;

    localparam int          CH     = 3;
    localparam int          FRAC   = 32;
    localparam int          WARM   = 16;
    localparam logic [63:0] GOLDEN = 64'h9E37_79B9_7F4A_7C15;

    logic         clk = 1'b0;
    logic         rst;
    logic         seed_load, rdy;
    logic [63:0]  seed_in;
    logic [1:0]   mode_in;
    logic         valid;
    logic [191:0] rout;
    logic [31:0]  dcount;

    logic         seed_load2, rdy2;
    logic [63:0]  seed_in2;
    logic [1:0]   mode_in2;
    logic         valid2;
    logic [63:0]  rout2;
    logic [31:0]  dcount2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rand_stream dut (
        .i_clk(clk), .i_rst(rst), .i_seed_load(seed_load), .i_seed_in(seed_in),
        .i_mode_in(mode_in), .i_rand_ready(rdy), .o_rand_valid(valid),
        .o_rand_out(rout), .o_draw_count(dcount)
    );

    rand_stream #(.CHANNELS(1), .WARMUP(0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_seed_load(seed_load2), .i_seed_in(seed_in2),
        .i_mode_in(mode_in2), .i_rand_ready(rdy2), .o_rand_valid(valid2),
        .o_rand_out(rout2), .o_draw_count(dcount2)
    );

    // ---------------- behavioural model ----------------
    logic [63:0] m_s [CH];
    logic [1:0]  m_mode;
    logic [31:0] m_cnt;
    int          m_warm;

    function automatic logic [63:0] xs(input logic [63:0] s);
        s = s ^ (s << 13);
        s = s ^ (s >> 7);
        s = s ^ (s << 17);
        return s;
    endfunction

    function automatic logic [63:0] seed_of(input logic [63:0] seed, input int c);
        logic [63:0] v;
        v = seed ^ (64'(c) * GOLDEN);
        if (v == 64'd0) v = 64'd1;
        return v;
    endfunction

    function automatic logic [63:0] fmt(input logic [63:0] s, input logic [1:0] mode);
        logic [63:0] sh;
        case (mode)
            2'd1: return s & ((64'd1 << FRAC) - 64'd1);
            2'd2: begin
                sh = s << (63 - FRAC);
                return 64'($signed(sh) >>> (63 - FRAC));
            end
            default: return s;
        endcase
    endfunction

    function automatic logic [191:0] exp_out();
        logic [191:0] e;
        for (int c = 0; c < CH; c++) e[c*64 +: 64] = fmt(m_s[c], m_mode);
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) m_s[c] = seed_of(64'd1, c);
        m_mode = 2'd0;
        m_cnt  = 32'd0;
        m_warm = WARM;
    endtask

    task automatic model_edge(input logic sl, input logic [63:0] sd, input logic [1:0] md,
                              input logic r);
        if (sl) begin
            for (int c = 0; c < CH; c++) m_s[c] = seed_of(sd, c);
            m_mode = md;
            m_cnt  = 32'd0;
            m_warm = WARM;
        end else if (m_warm > 0) begin
            for (int c = 0; c < CH; c++) m_s[c] = xs(m_s[c]);
            m_warm--;
        end else if (r) begin
            for (int c = 0; c < CH; c++) m_s[c] = xs(m_s[c]);
            m_cnt++;
        end
    endtask

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic compare_main();
        chk("valid", {191'd0, valid}, {191'd0, (m_warm == 0)});
        chk("rand_out", rout, exp_out());
        chk("draw_count", {160'd0, dcount}, {160'd0, m_cnt});
    endtask

    // drive at negedge, model the coming edge, compare at the following negedge
    task automatic step_main(input logic sl, input logic [63:0] sd, input logic [1:0] md,
                             input logic r);
        seed_load = sl; seed_in = sd; mode_in = md; rdy = r;
        model_edge(sl, sd, md, r);
        @(posedge clk);
        @(negedge clk);
        compare_main();
    endtask

    task automatic step2(input logic sl, input logic [63:0] sd, input logic [1:0] md,
                         input logic r);
        seed_load2 = sl; seed_in2 = sd; mode_in2 = md; rdy2 = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        seed_load = 1'b0; rdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", {191'd0, valid}, 192'd0);
        chk("rst_count", {160'd0, dcount}, 192'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic warm_len(input string nm);
        int n = 0;
        while (!valid && n < 40) begin
            step_main(1'b0, 64'd0, 2'd0, 1'b1);
            n++;
        end
        chk(nm, 192'(n), 192'(WARM));
    endtask

    logic [191:0] held;
    logic [31:0]  held_cnt;
    logic [63:0]  sd;

    initial begin
        rst = 1'b1;
        seed_load = 0; seed_in = 0; mode_in = 0; rdy = 0;
        seed_load2 = 0; seed_in2 = 0; mode_in2 = 0; rdy2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", {191'd0, valid}, 192'd0);
        chk("reset_count", {160'd0, dcount}, 192'd0);
        chk("reset_out", rout, exp_out());
        chk("reset_valid_nowarm", {191'd0, valid2}, 192'd1);
        rst = 1'b0;

        warm_len("poweron_warm_len");

        // stall: output and count must hold, then exactly one accept
        step_main(1'b0, 64'd0, 2'd0, 1'b1);
        held = rout; held_cnt = dcount;
        for (int i = 0; i < 10; i++) begin
            step_main(1'b0, 64'd0, 2'd0, 1'b0);
            chk("stall_out", rout, held);
            chk("stall_count", {160'd0, dcount}, {160'd0, held_cnt});
        end
        step_main(1'b0, 64'd0, 2'd0, 1'b1);
        chk("stall_accept_once", {160'd0, dcount}, {160'd0, held_cnt + 32'd1});

        // seed_load wins over a same-edge accept
        step_main(1'b1, 64'h1234_5678_9ABC_DEF0, 2'd1, 1'b1);
        chk("load_beats_accept", {160'd0, dcount}, 192'd0);
        warm_len("reload_warm_len");

        // reset mid-warm-up restarts warm-up at full length
        step_main(1'b1, 64'hCAFE_F00D_0000_0042, 2'd2, 1'b1);
        repeat (5) step_main(1'b0, 64'd0, 2'd0, 1'b1);
        pulse_reset();
        warm_len("midwarm_reset_warm_len");

        // channel 1 seed collapses to zero and must become 1
        step_main(1'b1, GOLDEN, 2'd0, 1'b1);
        warm_len("golden_warm_len");
        chk("ch1_from_zero_seed", {128'd0, rout[127:64]}, {128'd0, 64'h0} | 192'(m_s[1]));

        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       sd = 64'd0;
                1:       sd = GOLDEN;
                2:       sd = GOLDEN * 64'd2;
                default: sd = {$urandom, $urandom};
            endcase
            if (r < 2) pulse_reset();
            else step_main(r < 6, sd, 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 65);
        end

        // single channel, no warm-up: literal expectations
        step2(1'b1, 64'h1, 2'd0, 1'b0);
        chk("nw_valid", {191'd0, valid2}, 192'd1);
        chk("nw_first", {128'd0, rout2}, 192'h1);
        step2(1'b0, 64'd0, 2'd0, 1'b1);
        chk("nw_step1", {128'd0, rout2}, 192'h4082_2041);
        chk("nw_count1", {160'd0, dcount2}, 192'd1);
        step2(1'b1, 64'd0, 2'd0, 1'b0);
        chk("nw_zero_seed", {128'd0, rout2}, 192'h1);
        chk("nw_count_clr", {160'd0, dcount2}, 192'd0);
        step2(1'b1, 64'hFFFF_FFFF_8000_0001, 2'd1, 1'b0);
        chk("nw_mode1", {128'd0, rout2}, 192'h0000_0000_8000_0001);
        step2(1'b1, 64'hFFFF_FFFF_8000_0001, 2'd2, 1'b0);
        chk("nw_mode2", {128'd0, rout2}, 192'hFFFF_FFFF_8000_0001);
        chk("nw_mode2_bit32", {191'd0, rout2[32]}, 192'd1);
        step2(1'b0, 64'd0, 2'd0, 1'b0);
        chk("nw_mode2_hold", {128'd0, rout2}, 192'hFFFF_FFFF_8000_0001);
        step2(1'b1, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0);
        chk("nw_mode3_raw", {128'd0, rout2}, 192'h0123_4567_89AB_CDEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rand_stream.md
RAND_STREAM -- requirements
Module: rand_stream

Interface
REQ-001 Parameter WIDTH, 64, output bits per channel; legal range 8..64.
REQ-002 Parameter CHANNELS, 3, independent generator channels; legal range 1..8.
REQ-003 Parameter FRAC, 32, fractional bits used by the scaled modes; FRAC < WIDTH.
REQ-004 Parameter WARMUP, 16, generator steps discarded after reset or a seed load; 0..255.
REQ-005 Parameter DEFAULT_SEED, 64'h0000_0000_0000_0001, seed applied at reset.
REQ-006 Parameter DEFAULT_MODE, 2'd0, output mode applied at reset.
REQ-007 Clk  input  1  the single clock; all state changes on its rising edge.
REQ-008 Reset  input  1  asynchronous, active-high reset.
REQ-009 seed_load  input  1  load seed_in and mode_in on this edge.
REQ-010 seed_in  input  64  seed value.
REQ-011 mode_in  input  2  output mode: 0 raw, 1 unit [0,1), 2 signed [-1,1); 3 is treated as 0.
REQ-012 rand_ready  input  1  consumer accepts the current sample.
REQ-013 rand_valid  output  1  rand_out holds a valid sample.
REQ-014 rand_out  output  CHANNELS x WIDTH  one sample per channel; channel c is in slice c.
REQ-015 draw_count  output  32  number of accepted samples since the last reset or seed load.

Function
REQ-016 Each channel SHALL hold a 64-bit xorshift state s; one step is: s^=s<<13; s^=s>>7; s^=s<<17.
REQ-017 The seed for channel c SHALL be seed ^ (c * 64'h9E3779B97F4A7C15), truncated to 64 bits; a zero result SHALL be replaced by 64'h1.
REQ-018 FSM states: WARM and RUN; rand_valid SHALL equal (state==RUN).
REQ-019 A seed_load SHALL, on the next edge, load every channel seed, latch mode_in, clear draw_count, and load warm_cnt=WARMUP; the next state SHALL be WARM if WARMUP>0, else RUN.
REQ-020 In WARM, each cycle SHALL step all channels and decrement warm_cnt; on the edge where warm_cnt goes 1->0 the FSM SHALL enter RUN.
REQ-021 In RUN, rand_valid&&rand_ready SHALL step all channels and increment draw_count (mod 2^32) on that edge.
REQ-022 While rand_valid&&!rand_ready, rand_out, the states and draw_count SHALL hold.
REQ-023 seed_load SHALL take priority over an accept or a warm-up step on the same edge; that accept SHALL NOT be counted.
REQ-024 rand_out SHALL be a function of registered state and the latched mode only; it has no combinational path from any input.
REQ-025 Mode 0: rand_out[c] = s_c[WIDTH-1:0].
REQ-026 Mode 1: bits [FRAC-1:0] = s_c[FRAC-1:0]; all higher bits = 0.
REQ-027 Mode 2: bits [FRAC:0] = s_c[FRAC:0], sign-extended from bit FRAC to WIDTH.
REQ-028 Channels SHALL always step together; no channel advances alone.

Reset
REQ-029 Reset high SHALL asynchronously load the DEFAULT_SEED-derived states, set mode=DEFAULT_MODE, draw_count=0 and warm_cnt=WARMUP, and set the FSM to WARM (or to RUN if WARMUP=0).
REQ-030 rand_valid SHALL be 0 during reset whenever WARMUP>0.
REQ-031 A reset asserted mid-warm-up or mid-stall SHALL discard all progress; on release, behaviour SHALL be identical to power-on.

Verification
REQ-032 CHANNELS=1, WARMUP=0, mode 0: seed_load with seed_in=1 -> next cycle rand_valid=1 and rand_out=64'h1; after one accept, rand_out=64'h40822041 and draw_count=1.
REQ-033 WARMUP=16, rand_ready=1 constantly after a seed load -> rand_valid stays 0 for exactly 16 cycles; the first sample equals the 16th step of the seed.
REQ-034 Stall: hold rand_ready=0 for 10 cycles while valid -> rand_out and draw_count remain constant; raising rand_ready then accepts that held sample exactly once.
REQ-035 seed_in=0 on channel 0 -> channel 0 state=64'h1; seed_in=64'h9E3779B97F4A7C15, CHANNELS=2 -> channel 1 state=64'h1, never zero.
REQ-036 Mode 1/2, FRAC=32, state 64'hFFFF_FFFF_8000_0001 -> mode 1 gives 64'h0000_0000_8000_0001; mode 2 gives 64'hFFFF_FFFF_8000_0001 with bit 32=1.
REQ-037 seed_load on the same edge as an accept, and Reset pulsed mid-warm-up -> draw_count=0 and the warm-up restarts at full length.
